// File: rtl/biquad_serial.sv
// Serial direct-form-I biquad: one shared multiplier walks the five taps in
// turn, so a new sample can be accepted at most once every seven clocks.
module biquad_serial #(
   parameter int DATAWIDTH = 12,
   parameter int COEFWIDTH = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        x_valid_i,
   input  logic signed [DATAWIDTH-1:0] x_i,
   input  logic [31:0]                 a11,
   input  logic [31:0]                 a12,
   input  logic [31:0]                 b10,
   input  logic [31:0]                 b11,
   input  logic [31:0]                 b12,
   output logic signed [DATAWIDTH-1:0] y_o,
   output logic                        y_valid_o,
   output logic                        busy_o,
   output logic                        drop_o
);

   localparam int PRODW = DATAWIDTH + COEFWIDTH;
   localparam int ACCW  = DATAWIDTH + COEFWIDTH + 3;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MAC  = 2'd1;
   localparam logic [1:0] ST_OUT  = 2'd2;

   localparam logic signed [ACCW-1:0] ROUND_C =
      {{(ACCW-COEFWIDTH+1){1'b0}}, 1'b1, {(COEFWIDTH-2){1'b0}}};
   localparam logic signed [ACCW-1:0] Y_MAX =
      {{(ACCW-DATAWIDTH+1){1'b0}}, {(DATAWIDTH-1){1'b1}}};
   localparam logic signed [ACCW-1:0] Y_MIN =
      {{(ACCW-DATAWIDTH+1){1'b1}}, {(DATAWIDTH-1){1'b0}}};

   logic [1:0]                 state_reg;
   logic [2:0]                 step_reg;
   logic signed [ACCW-1:0]     acc_reg;
   logic signed [ACCW-1:0]     acc_next;
   logic signed [DATAWIDTH-1:0] x0_reg, x1_reg, x2_reg, y1_reg, y2_reg;
   logic signed [DATAWIDTH-1:0] y_reg;
   logic                       y_valid_reg, busy_reg, drop_reg;

   // Coefficients in tap order: b10, b11, b12, a11, a12
   logic [159:0]                coef_bus;
   logic signed [COEFWIDTH-1:0] coef_in  [5];
   logic signed [COEFWIDTH-1:0] coef_reg [5];

   assign coef_bus = {a12, a11, b12, b11, b10};

   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_coef
         assign coef_in[gi] = coef_bus[gi*32 +: COEFWIDTH];
      end
   endgenerate

   logic unused_coef_bits;
   assign unused_coef_bits = ^{a11[31:COEFWIDTH], a12[31:COEFWIDTH],
                               b10[31:COEFWIDTH], b11[31:COEFWIDTH],
                               b12[31:COEFWIDTH]};

   logic accept;
   assign accept = (state_reg == ST_IDLE) && x_valid_i;

   // Snapshot is only meaningful once a sample is accepted, so no reset needed
   always_ff @(posedge clk_i) begin
      if (!rst_i && accept) begin
         for (int i = 0; i < 5; i++) begin
            coef_reg[i] <= coef_in[i];
         end
      end
   end

   logic signed [DATAWIDTH-1:0] sample_sel;
   logic signed [COEFWIDTH-1:0] coef_sel;
   logic signed [PRODW-1:0]     prod;
   logic signed [ACCW-1:0]      prod_ext;

   always_comb begin
      sample_sel = x0_reg;
      coef_sel   = coef_reg[0];
      case (step_reg)
         3'd0: begin sample_sel = x0_reg; coef_sel = coef_reg[0]; end
         3'd1: begin sample_sel = x1_reg; coef_sel = coef_reg[1]; end
         3'd2: begin sample_sel = x2_reg; coef_sel = coef_reg[2]; end
         3'd3: begin sample_sel = y1_reg; coef_sel = coef_reg[3]; end
         3'd4: begin sample_sel = y2_reg; coef_sel = coef_reg[4]; end
         default: begin sample_sel = x0_reg; coef_sel = coef_reg[0]; end
      endcase
   end

   assign prod     = sample_sel * coef_sel;
   assign prod_ext = {{(ACCW-PRODW){prod[PRODW-1]}}, prod};
   // Feedback taps (steps 3 and 4) are subtracted
   assign acc_next = (step_reg < 3'd3) ? acc_reg + prod_ext : acc_reg - prod_ext;

   logic signed [ACCW-1:0]      acc_round;
   logic signed [ACCW-1:0]      acc_shift;
   logic signed [DATAWIDTH-1:0] y_sat;

   assign acc_round = acc_reg + ROUND_C;
   assign acc_shift = acc_round >>> (COEFWIDTH-1);

   always_comb begin
      y_sat = acc_shift[DATAWIDTH-1:0];
      if (acc_shift > Y_MAX) begin
         y_sat = Y_MAX[DATAWIDTH-1:0];
      end else if (acc_shift < Y_MIN) begin
         y_sat = Y_MIN[DATAWIDTH-1:0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg   <= ST_IDLE;
         step_reg    <= 3'd0;
         acc_reg     <= '0;
         x0_reg      <= '0;
         x1_reg      <= '0;
         x2_reg      <= '0;
         y1_reg      <= '0;
         y2_reg      <= '0;
         y_reg       <= '0;
         y_valid_reg <= 1'b0;
         busy_reg    <= 1'b0;
         drop_reg    <= 1'b0;
      end else begin
         y_valid_reg <= 1'b0;
         drop_reg    <= x_valid_i && (state_reg != ST_IDLE);
         case (state_reg)
            ST_IDLE: begin
               if (x_valid_i) begin
                  x0_reg    <= x_i;
                  acc_reg   <= '0;
                  step_reg  <= 3'd0;
                  state_reg <= ST_MAC;
                  busy_reg  <= 1'b1;
               end
            end
            ST_MAC: begin
               acc_reg <= acc_next;
               if (step_reg == 3'd4) begin
                  step_reg  <= 3'd0;
                  state_reg <= ST_OUT;
               end else begin
                  step_reg <= step_reg + 3'd1;
               end
            end
            ST_OUT: begin
               y_reg       <= y_sat;
               y_valid_reg <= 1'b1;
               x2_reg      <= x1_reg;
               x1_reg      <= x0_reg;
               y2_reg      <= y1_reg;
               y1_reg      <= y_sat;
               state_reg   <= ST_IDLE;
               busy_reg    <= 1'b0;
            end
            default: begin
               state_reg <= ST_IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign y_o       = y_reg;
   assign y_valid_o = y_valid_reg;
   assign busy_o    = busy_reg;
   assign drop_o    = drop_reg;

endmodule

// File: tb/tb_biquad_serial.sv
// Bench for biquad_serial: a transaction-level model predicts every output
// each cycle, and directed vectors pin the model with hand-computed results.
module tb_biquad_serial;

   localparam int DW = 12;
   localparam int CW = 16;

   logic                 clk;
   logic                 rst;
   logic                 x_valid;
   logic signed [DW-1:0] x_in;
   logic [31:0]          a11, a12, b10, b11, b12;
   logic signed [DW-1:0] y_o;
   logic                 y_valid_o, busy_o, drop_o;

   int checks   = 0;
   int failures = 0;

   biquad_serial #(.DATAWIDTH(DW), .COEFWIDTH(CW)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .x_valid_i (x_valid),
      .x_i       (x_in),
      .a11       (a11),
      .a12       (a12),
      .b10       (b10),
      .b11       (b11),
      .b12       (b12),
      .y_o       (y_o),
      .y_valid_o (y_valid_o),
      .busy_o    (busy_o),
      .drop_o    (drop_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint coef(input logic [31:0] c);
      logic signed [CW-1:0] v;
      v = c[CW-1:0];
      return longint'(v);
   endfunction

   function automatic longint round_sat(input longint acc);
      longint r;
      r = (acc + (longint'(1) << (CW-2))) >>> (CW-1);
      if (r > 2047) r = 2047;
      if (r < -2048) r = -2048;
      return r;
   endfunction

   // Reference model: one accepted sample yields its result 7 edges later
   int     m_phase;
   bit     model_ok = 1'b0;
   longint m_x0, m_x1, m_x2, m_y1, m_y2, m_pend, m_y;
   bit     m_yv, m_busy, m_drop;

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0;
         m_x0 = 0; m_x1 = 0; m_x2 = 0; m_y1 = 0; m_y2 = 0;
         m_y = 0; m_yv = 0; m_busy = 0; m_drop = 0;
         model_ok = 1'b1;
      end else if (model_ok) begin
         m_yv   = 0;
         m_drop = 0;
         if (m_phase == 0) begin
            if (x_valid) begin
               m_x0   = longint'(x_in);
               m_pend = round_sat(coef(b10) * m_x0 + coef(b11) * m_x1 + coef(b12) * m_x2
                                  - coef(a11) * m_y1 - coef(a12) * m_y2);
               m_phase = 1;
               m_busy  = 1;
            end
         end else begin
            m_drop = x_valid;
            if (m_phase == 6) begin
               m_y  = m_pend;
               m_yv = 1;
               m_x2 = m_x1; m_x1 = m_x0;
               m_y2 = m_y1; m_y1 = m_pend;
               m_phase = 0;
               m_busy  = 0;
            end else begin
               m_phase++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         check("model_y_o", longint'(y_o), m_y);
         check("model_y_valid", longint'(y_valid_o), longint'(m_yv));
         check("model_busy", longint'(busy_o), longint'(m_busy));
         check("model_drop", longint'(drop_o), longint'(m_drop));
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic set_coefs(input logic [31:0] c_b10, input logic [31:0] c_b11,
                            input logic [31:0] c_b12, input logic [31:0] c_a11,
                            input logic [31:0] c_a12);
      b10 = c_b10; b11 = c_b11; b12 = c_b12; a11 = c_a11; a12 = c_a12;
   endtask

   // Strobe one sample, then measure latency, busy length and the result
   task automatic send_measure(input string name, input int x, input int exp_y);
      int  lat;
      int  busy_n;
      bit  got;
      @(negedge clk);
      x_valid = 1'b1;
      x_in    = DW'(x);
      lat = 0; busy_n = 0; got = 1'b0;
      for (int k = 1; k <= 20 && !got; k++) begin
         @(negedge clk);
         x_valid = 1'b0;
         if (busy_o) busy_n++;
         if (y_valid_o) begin
            got = 1'b1;
            lat = k;
         end
      end
      $display("txn %s: x=%0d y=%0d latency=%0d busy=%0d", name, x, y_o, lat, busy_n);
      check({name, "_y"}, longint'(y_o), longint'(exp_y));
      check({name, "_latency"}, longint'(lat), 7);
      check({name, "_busy_cycles"}, longint'(busy_n), 6);
   endtask

   initial begin
      int drops;
      int yv_seen;
      rst = 1'b1; x_valid = 1'b0; x_in = '0;
      set_coefs(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      @(negedge clk);
      check("reset_y_o", longint'(y_o), 0);
      check("reset_busy", longint'(busy_o), 0);
      rst = 1'b0;

      // Passthrough with junk in the unused upper coefficient bits
      do_reset();
      set_coefs(32'hDEAD_7FFF, 32'hBEEF_0000, 32'h1234_0000, 32'h5678_0000, 32'h9ABC_0000);
      send_measure("passthrough", 1000, 1000);

      // One-sample delay at half gain
      do_reset();
      set_coefs(32'h0, 32'h4000, 32'h0, 32'h0, 32'h0);
      send_measure("delay_0", 1000, 0);
      send_measure("delay_1", 0, 500);

      // Saturation both ways
      do_reset();
      set_coefs(32'h7FFF, 32'h7FFF, 32'h0, 32'h0, 32'h0);
      send_measure("sat_pos_0", 2047, 2047);
      send_measure("sat_pos_1", 2047, 2047);
      do_reset();
      send_measure("sat_neg_0", -2048, -2048);
      send_measure("sat_neg_1", -2048, -2048);

      // Recursive decay through a11 = -0.5
      do_reset();
      set_coefs(32'h7FFF, 32'h0, 32'h0, 32'hC000, 32'h0);
      send_measure("feedback_0", 1000, 1000);
      send_measure("feedback_1", 0, 500);
      send_measure("feedback_2", 0, 250);
      send_measure("feedback_3", 0, 125);

      // Second strobe and a coefficient write while busy
      do_reset();
      set_coefs(32'h7FFF, 32'h0, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      x_valid = 1'b1; x_in = 12'sd800;
      @(negedge clk);
      x_valid = 1'b0;
      @(negedge clk);
      x_valid = 1'b1; x_in = 12'sd100;
      b10 = 32'h0000_4000;
      drops = 0; yv_seen = 0;
      for (int k = 0; k < 20 && yv_seen == 0; k++) begin
         @(negedge clk);
         x_valid = 1'b0;
         if (drop_o) drops++;
         if (y_valid_o) yv_seen = 1;
      end
      $display("txn busy_drop: y=%0d drops=%0d", y_o, drops);
      check("busy_drop_count", longint'(drops), 1);
      check("busy_drop_y", longint'(y_o), 800);
      check("busy_drop_yvalid", longint'(yv_seen), 1);
      send_measure("coef_reload", 800, 400);

      // Reset in the middle of a computation
      do_reset();
      set_coefs(32'h7FFF, 32'h4000, 32'h0, 32'h0, 32'h0);
      send_measure("pre_reset", 1000, 1000);
      @(negedge clk);
      x_valid = 1'b1; x_in = 12'sd300;
      @(negedge clk);
      x_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("midreset_y_o", longint'(y_o), 0);
      check("midreset_yvalid", longint'(y_valid_o), 0);
      check("midreset_busy", longint'(busy_o), 0);
      check("midreset_drop", longint'(drop_o), 0);
      yv_seen = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (y_valid_o) yv_seen++;
      end
      $display("txn mid_reset: y=%0d stray_valids=%0d", y_o, yv_seen);
      check("midreset_no_valid", longint'(yv_seen), 0);
      send_measure("post_reset", 600, 600);

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
